// File: rtl/x_oserdes_tx_if.sv
// Parallel word handshake into the serializer: the source drives D/DVALID,
// and the serializer returns DREADY.
interface x_oserdes_tx_if #(
    parameter int DATA_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0] D;
    logic                  DVALID;
    logic                  DREADY;

    modport master (output D, output DVALID, input DREADY);
    modport slave  (input D, input DVALID, output DREADY);
endinterface

// File: rtl/x_oserdes_tx.sv
// Parallel-to-serial transmitter. A holding register sits in front of the
// shift register, so back-to-back words leave OQ with no gap bits.
module x_oserdes_tx #(
    parameter int    DATA_WIDTH = 4,
    parameter string MSB_FIRST  = "FALSE",
    parameter logic  SRVAL_OQ   = 1'b0
) (
    input  logic           CLK,
    input  logic           SR_N,
    input  logic           CE,
    x_oserdes_tx_if.slave  s_if,
    output logic           OQ,
    output logic           TQ,
    output logic           FRAME,
    output logic           UNDERRUN
);
    localparam int              CW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam bit              SEND_MSB = (MSB_FIRST == "TRUE");

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
        $fatal(1, "x_oserdes_tx: DATA_WIDTH must be in 2..8");
    end

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_shr;
    logic [CW-1:0]         r_cnt;
    logic                  r_oq;
    logic                  r_tq;
    logic                  r_frame;
    logic                  r_underrun;

    logic                  w_dready;
    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_word;

    // The word is reordered once at load so the shifter always emits bit 0 next.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
        assign w_load_word[gi] = SEND_MSB ? r_hold[DATA_WIDTH-1-gi] : r_hold[gi];
    end

    assign w_dready    = SR_N & CE & ~r_hold_full;
    assign w_accept    = s_if.DVALID & w_dready;
    assign w_last_bit  = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
    assign w_load      = r_hold_full && ((r_state == ST_IDLE) || w_last_bit);
    assign s_if.DREADY = w_dready;

    // NOTE: every register here uses <= so all updates see pre-edge values; reset is synchronous to CLK.
    always_ff @(posedge CLK) begin
        if (!SR_N) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shr       <= '0;
            r_cnt       <= '0;
            r_oq        <= SRVAL_OQ;
            r_tq        <= 1'b1;
            r_frame     <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (CE) begin
            r_underrun <= 1'b0;
            if (w_accept) begin
                r_hold      <= s_if.D;
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                r_shr       <= {1'b0, w_load_word[DATA_WIDTH-1:1]};
                r_oq        <= w_load_word[0];
                r_cnt       <= '0;
                r_frame     <= 1'b1;
                r_tq        <= 1'b0;
                r_hold_full <= 1'b0;
                r_state     <= ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                r_frame <= 1'b0;
                if (w_last_bit) begin
                    r_state    <= ST_IDLE;
                    r_oq       <= SRVAL_OQ;
                    r_tq       <= 1'b1;
                    r_underrun <= 1'b1;
                end else begin
                    r_shr <= {1'b0, r_shr[DATA_WIDTH-1:1]};
                    r_oq  <= r_shr[0];
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign OQ       = r_oq;
    assign TQ       = r_tq;
    assign FRAME    = r_frame;
    assign UNDERRUN = r_underrun;
endmodule

// File: tb/tb_x_oserdes_tx.sv
// Directed bench for x_oserdes_tx: a 4-bit LSB-first instance and an 8-bit
// MSB-first instance, checked cycle by cycle against an expected-output queue.
module tb_x_oserdes_tx;
    localparam logic SRV_A = 1'b0;
    localparam logic SRV_B = 1'b1;

    logic clk = 1'b0;
    logic sr_n;
    logic ce;
    logic oq_a, tq_a, fr_a, un_a;
    logic oq_b, tq_b, fr_b, un_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {OQ, TQ, FRAME, UNDERRUN} per cycle, one queue per instance.
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    x_oserdes_tx_if #(.DATA_WIDTH(4)) if_a ();
    x_oserdes_tx_if #(.DATA_WIDTH(8)) if_b ();

    x_oserdes_tx #(.DATA_WIDTH(4), .MSB_FIRST("FALSE"), .SRVAL_OQ(SRV_A)) dut_a (
        .CLK(clk), .SR_N(sr_n), .CE(ce), .s_if(if_a),
        .OQ(oq_a), .TQ(tq_a), .FRAME(fr_a), .UNDERRUN(un_a)
    );

    x_oserdes_tx #(.DATA_WIDTH(8), .MSB_FIRST("TRUE"), .SRVAL_OQ(SRV_B)) dut_b (
        .CLK(clk), .SR_N(sr_n), .CE(ce), .s_if(if_b),
        .OQ(oq_b), .TQ(tq_b), .FRAME(fr_b), .UNDERRUN(un_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tp(input logic o, input logic t, input logic f, input logic u);
        return {o, t, f, u};
    endfunction

    task automatic push_word_a(input logic [3:0] w);
        for (int i = 0; i < 4; i++) qa.push_back(tp(w[i], 1'b0, i == 0, 1'b0));
    endtask

    task automatic push_word_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) qb.push_back(tp(w[7-i], 1'b0, i == 0, 1'b0));
    endtask

    // One clock edge, then compare both instances at the falling edge.
    task automatic tick(input string tag);
        logic [3:0] e;
        @(posedge clk);
        @(negedge clk);
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check({tag, "_a"}, {28'd0, oq_a, tq_a, fr_a, un_a}, {28'd0, e});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check({tag, "_b"}, {28'd0, oq_b, tq_b, fr_b, un_b}, {28'd0, e});
        end
    endtask

    initial begin
        sr_n = 1'b0;
        ce = 1'b1;
        if_a.D = '0;
        if_a.DVALID = 1'b1;
        if_b.D = '0;
        if_b.DVALID = 1'b1;

        // 1: reset held for three edges with DVALID asserted
        for (int i = 0; i < 3; i++) begin
            qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
            qb.push_back(tp(SRV_B, 1'b1, 1'b0, 1'b0));
            tick("reset");
            check("reset_dready_a", {31'd0, if_a.DREADY}, 32'd0);
        end
        if_a.DVALID = 1'b0;
        if_b.DVALID = 1'b0;
        sr_n = 1'b1;
        #1;
        check("release_dready_a", {31'd0, if_a.DREADY}, 32'd1);
        check("release_dready_b", {31'd0, if_b.DREADY}, 32'd1);

        // 2: single word 4'b1011, LSB first -> 1,1,0,1 then underrun
        if_a.D = 4'b1011;
        if_a.DVALID = 1'b1;
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        push_word_a(4'b1011);
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b1));
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        tick("single");
        if_a.DVALID = 1'b0;
        for (int i = 0; i < 6; i++) tick("single");

        // 3: 4'hA then 4'h5 back to back, second accepted during the first
        if_a.D = 4'hA;
        if_a.DVALID = 1'b1;
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        push_word_a(4'hA);
        push_word_a(4'h5);
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b1));
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        tick("b2b");
        if_a.DVALID = 1'b0;
        tick("b2b");
        if_a.D = 4'h5;
        if_a.DVALID = 1'b1;
        tick("b2b");
        if_a.DVALID = 1'b0;
        check("b2b_hold_full_dready", {31'd0, if_a.DREADY}, 32'd0);
        for (int i = 0; i < 8; i++) tick("b2b");

        // 4: CE low for two cycles while bit 1 of 4'b1011 is on OQ
        if_a.D = 4'b1011;
        if_a.DVALID = 1'b1;
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        qa.push_back(tp(1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) qa.push_back(tp(1'b1, 1'b0, 1'b0, 1'b0));
        qa.push_back(tp(1'b0, 1'b0, 1'b0, 1'b0));
        qa.push_back(tp(1'b1, 1'b0, 1'b0, 1'b0));
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b1));
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        tick("ce");
        if_a.DVALID = 1'b0;
        tick("ce");
        tick("ce");
        ce = 1'b0;
        #1;
        check("ce_low_dready", {31'd0, if_a.DREADY}, 32'd0);
        tick("ce");
        tick("ce");
        ce = 1'b1;
        for (int i = 0; i < 4; i++) tick("ce");

        // 5: reset mid-word with the holding register full
        if_a.D = 4'hA;
        if_a.DVALID = 1'b1;
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        qa.push_back(tp(1'b0, 1'b0, 1'b1, 1'b0));
        qa.push_back(tp(1'b1, 1'b0, 1'b0, 1'b0));
        qa.push_back(tp(1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        tick("mid_rst");
        if_a.DVALID = 1'b0;
        tick("mid_rst");
        if_a.D = 4'hF;
        if_a.DVALID = 1'b1;
        tick("mid_rst");
        if_a.DVALID = 1'b0;
        tick("mid_rst");
        check("mid_rst_hold_full", {31'd0, if_a.DREADY}, 32'd0);
        sr_n = 1'b0;
        tick("mid_rst");
        sr_n = 1'b1;
        #1;
        check("mid_rst_release_dready", {31'd0, if_a.DREADY}, 32'd1);
        tick("mid_rst");
        tick("mid_rst");
        if_a.D = 4'h3;
        if_a.DVALID = 1'b1;
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        push_word_a(4'h3);
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b1));
        qa.push_back(tp(SRV_A, 1'b1, 1'b0, 1'b0));
        tick("after_rst");
        if_a.DVALID = 1'b0;
        for (int i = 0; i < 6; i++) tick("after_rst");

        // 6: 8-bit MSB-first instance sends 8'hC3 -> 1,1,0,0,0,0,1,1
        if_b.D = 8'hC3;
        if_b.DVALID = 1'b1;
        qb.push_back(tp(SRV_B, 1'b1, 1'b0, 1'b0));
        push_word_b(8'hC3);
        qb.push_back(tp(SRV_B, 1'b1, 1'b0, 1'b1));
        qb.push_back(tp(SRV_B, 1'b1, 1'b0, 1'b0));
        tick("msb8");
        if_b.DVALID = 1'b0;
        for (int i = 0; i < 10; i++) tick("msb8");

        check("queue_a_drained", qa.size(), 32'd0);
        check("queue_b_drained", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
